// File: rtl/keypad_emulator.sv
// Switch side of a 4x5 matrix keypad: turns "press key K for N cycles" requests
// into open-drain pull-downs on keyX/keyY, with repeatable LFSR contact bounce.
module keypad_emulator #(
    parameter int         BOUNCE_CYC = 64,
    parameter int         GAP_CYC    = 256,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  keyX_in,
    input  logic [4:0]  keyY_in,
    output logic [3:0]  keyX_pd,
    output logic [4:0]  keyY_pd,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_code,
    input  logic [15:0] req_hold,
    output logic        busy,
    output logic        done,
    output logic        code_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BOUNCE_IN,
        S_HOLD,
        S_BOUNCE_OUT,
        S_GAP
    } state_t;

    localparam logic [15:0] BOUNCE_LD = 16'(BOUNCE_CYC);
    localparam logic [15:0] GAP_LD    = 16'(GAP_CYC);

    state_t      state;
    logic [15:0] cnt;
    logic [4:0]  code_q;
    logic [15:0] hold_q;
    logic [7:0]  lfsr;
    logic [7:0]  lfsr_next;
    logic        contact;
    logic [15:0] hold_in;
    logic [1:0]  x_q;
    logic [2:0]  y_q;
    logic [7:0]  ky_ext;

    // x^8+x^6+x^5+x^4+1, shifted towards the MSB
    assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign hold_in   = (req_hold == 16'd0) ? 16'd1 : req_hold;
    assign x_q       = code_q[1:0];
    assign y_q       = code_q[4:2];
    assign ky_ext    = {3'b111, keyY_in};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lfsr      <= LFSR_SEED;
            contact   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            code_err  <= 1'b0;
            req_ready <= 1'b0;
        end else begin
            done     <= 1'b0;
            code_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    contact   <= 1'b0;
                    if (req_valid && req_ready) begin
                        code_q    <= req_code;
                        hold_q    <= hold_in;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                        if (req_code[4:2] > 3'd4) begin
                            // no such row: skip the contact entirely, still honour the gap
                            code_err <= 1'b1;
                            if (GAP_CYC == 0) begin
                                state     <= S_IDLE;
                                busy      <= 1'b0;
                                req_ready <= 1'b1;
                                done      <= 1'b1;
                            end else begin
                                state <= S_GAP;
                                cnt   <= GAP_LD;
                            end
                        end else if (BOUNCE_CYC > 0) begin
                            state   <= S_BOUNCE_IN;
                            cnt     <= BOUNCE_LD;
                            contact <= (BOUNCE_CYC == 1) ? 1'b1 : lfsr[0];
                        end else begin
                            state   <= S_HOLD;
                            cnt     <= hold_in;
                            contact <= 1'b1;
                        end
                    end
                end

                S_BOUNCE_IN: begin
                    lfsr <= lfsr_next;
                    if (cnt == 16'd1) begin
                        state   <= S_HOLD;
                        cnt     <= hold_q;
                        contact <= 1'b1;
                    end else begin
                        cnt     <= cnt - 16'd1;
                        contact <= (cnt == 16'd2) ? 1'b1 : lfsr_next[0];
                    end
                end

                S_HOLD: begin
                    if (cnt == 16'd1) begin
                        if (BOUNCE_CYC > 0) begin
                            state   <= S_BOUNCE_OUT;
                            cnt     <= BOUNCE_LD;
                            contact <= (BOUNCE_CYC == 1) ? 1'b0 : lfsr[0];
                        end else if (GAP_CYC == 0) begin
                            state     <= S_IDLE;
                            contact   <= 1'b0;
                            busy      <= 1'b0;
                            req_ready <= 1'b1;
                            done      <= 1'b1;
                        end else begin
                            state   <= S_GAP;
                            cnt     <= GAP_LD;
                            contact <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end

                S_BOUNCE_OUT: begin
                    lfsr <= lfsr_next;
                    if (cnt == 16'd1) begin
                        contact <= 1'b0;
                        if (GAP_CYC == 0) begin
                            state     <= S_IDLE;
                            busy      <= 1'b0;
                            req_ready <= 1'b1;
                            done      <= 1'b1;
                        end else begin
                            state <= S_GAP;
                            cnt   <= GAP_LD;
                        end
                    end else begin
                        cnt     <= cnt - 16'd1;
                        contact <= (cnt == 16'd2) ? 1'b0 : lfsr_next[0];
                    end
                end

                S_GAP: begin
                    contact <= 1'b0;
                    if (cnt == 16'd1) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        done      <= 1'b1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    contact   <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    // Zero-delay switch: each side is gated only by the opposite line, never its own.
    always_comb begin
        keyX_pd = '0;
        keyY_pd = '0;
        for (int i = 0; i < 4; i++) begin
            keyX_pd[i] = contact && (x_q == 2'(i)) && !ky_ext[y_q];
        end
        for (int j = 0; j < 5; j++) begin
            keyY_pd[j] = contact && (y_q == 3'(j)) && !keyX_in[x_q];
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: per-cycle comparison against a
// trace-based reference model, a table of static-sense vectors and corner sequences.
module tb_keypad_emulator;

    localparam int         B    = 64;
    localparam int         G    = 32;
    localparam logic [7:0] SEED = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  keyX_in;
    logic [4:0]  keyY_in;
    logic [3:0]  keyX_pd;
    logic [4:0]  keyY_pd;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_code;
    logic [15:0] req_hold;
    logic        busy;
    logic        done;
    logic        code_err;

    always #5 clk = ~clk;

    keypad_emulator #(
        .BOUNCE_CYC (B),
        .GAP_CYC    (G),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .keyX_in   (keyX_in),
        .keyY_in   (keyY_in),
        .keyX_pd   (keyX_pd),
        .keyY_pd   (keyY_pd),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_code  (req_code),
        .req_hold  (req_hold),
        .busy      (busy),
        .done      (done),
        .code_err  (code_err)
    );

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    // Reference model: on acceptance the whole contact trace is laid out in a queue.
    bit       m_busy, m_ready, m_done, m_err, m_contact;
    bit [1:0] m_x;
    bit [2:0] m_y;
    bit [7:0] m_lfsr;
    bit       q[$];

    typedef struct {
        logic [3:0] kx;
        logic [4:0] ky;
        logic [3:0] ex;
        logic [4:0] ey;
    } vec_t;
    vec_t vt[6];

    function automatic bit [7:0] lfsr_step(input bit [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit acc;
        int h;
        if (!rst_n) begin
            m_busy = 0; m_ready = 0; m_done = 0; m_err = 0; m_contact = 0;
            q.delete();
            m_lfsr = SEED;
        end else begin
            acc = !m_busy && m_ready && req_valid;
            m_done = 0;
            m_err  = 0;
            if (acc) begin
                m_x   = req_code[1:0];
                m_y   = req_code[4:2];
                m_err = (m_y > 3'd4);
                q.delete();
                if (!m_err) begin
                    h = (req_hold == 16'd0) ? 1 : int'(req_hold);
                    for (int k = 0; k < B; k++) begin
                        q.push_back((k == B - 1) ? 1'b1 : m_lfsr[0]);
                        m_lfsr = lfsr_step(m_lfsr);
                    end
                    for (int k = 0; k < h; k++) q.push_back(1'b1);
                    for (int k = 0; k < B; k++) begin
                        q.push_back((k == B - 1) ? 1'b0 : m_lfsr[0]);
                        m_lfsr = lfsr_step(m_lfsr);
                    end
                end
                for (int k = 0; k < G; k++) q.push_back(1'b0);
                m_busy = 1;
            end
            if (m_busy) begin
                if (q.size() > 0) begin
                    m_contact = q.pop_front();
                end else begin
                    m_busy    = 0;
                    m_done    = 1;
                    m_contact = 0;
                end
            end
            m_ready = !m_busy;
        end
    endtask

    task automatic check_all();
        logic [3:0] ex;
        logic [4:0] ey;
        ex = '0;
        ey = '0;
        if (m_contact) begin
            ex[m_x] = !keyY_in[m_y];
            ey[m_y] = !keyX_in[m_x];
        end
        chk("busy", 32'(busy), 32'(m_busy));
        chk("req_ready", 32'(req_ready), 32'(m_ready));
        chk("done", 32'(done), 32'(m_done));
        chk("code_err", 32'(code_err), 32'(m_err));
        chk("keyX_pd", 32'(keyX_pd), 32'(ex));
        chk("keyY_pd", 32'(keyY_pd), 32'(ey));
        if (done === 1'b1) done_cnt++;
        if (code_err === 1'b1) err_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("ready_after_reset", 32'(req_ready), 32'd1);
    endtask

    task automatic send(input logic [4:0] code, input logic [15:0] hold);
        int n;
        n = 0;
        while (!m_ready && n < 5000) begin
            tick();
            n++;
        end
        if (n >= 5000) chk("send_timeout", 32'(n), 32'd0);
        req_valid = 1'b1;
        req_code  = code;
        req_hold  = hold;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_busy && n < 20000) begin
            tick();
            n++;
        end
        if (n >= 20000) chk("idle_timeout", 32'(n), 32'd0);
    endtask

    task automatic bounce_trace(input string name);
        bit [7:0] s;
        logic     e;
        s = SEED;
        send(5'b00000, 16'd5);
        for (int k = 0; k < B; k++) begin
            if (k > 0) tick();
            e = (k == B - 1) ? 1'b1 : s[0];
            chk(name, 32'(keyX_pd[0]), 32'(e));
            s = lfsr_step(s);
        end
        wait_idle();
    endtask

    initial begin
        int d0, e0, n, lowcnt;
        logic anypd;

        vt[0] = '{kx: 4'hF,    ky: 5'b11011, ex: 4'b0010, ey: 5'b00000};
        vt[1] = '{kx: 4'hF,    ky: 5'h1F,    ex: 4'b0000, ey: 5'b00000};
        vt[2] = '{kx: 4'b1101, ky: 5'h1F,    ex: 4'b0000, ey: 5'b00100};
        vt[3] = '{kx: 4'b1101, ky: 5'b11011, ex: 4'b0010, ey: 5'b00100};
        vt[4] = '{kx: 4'b0010, ky: 5'b00100, ex: 4'b0000, ey: 5'b00000};
        vt[5] = '{kx: 4'h0,    ky: 5'h00,    ex: 4'b0010, ey: 5'b00100};

        rst_n = 1'b0; req_valid = 1'b0; req_code = '0; req_hold = '0;
        keyX_in = 4'hF; keyY_in = 5'h1F;
        do_reset();

        // Static sense with key X=1, Y=2 held solid
        send(5'b01001, 16'd200);
        repeat (B + 5) tick();
        for (int i = 0; i < 6; i++) begin
            keyX_in = vt[i].kx;
            keyY_in = vt[i].ky;
            tick();
            chk($sformatf("vec%0d_keyX_pd", i), 32'(keyX_pd), 32'(vt[i].ex));
            chk($sformatf("vec%0d_keyY_pd", i), 32'(keyY_pd), 32'(vt[i].ey));
        end
        keyX_in = 4'hF; keyY_in = 5'h1F;
        wait_idle();

        // Bounce pattern from the seed, twice after reset
        keyY_in = 5'h00;
        do_reset();
        bounce_trace("bounce_run1");
        do_reset();
        bounce_trace("bounce_run2");

        // Long press of X=2, Y=2: done exactly once
        d0 = done_cnt;
        send(5'b01010, 16'd1000);
        wait_idle();
        tick();
        chk("long_press_done_once", 32'(done_cnt - d0), 32'd1);

        // Back-to-back with req_valid held high
        req_valid = 1'b1; req_code = 5'b00011; req_hold = 16'd3;
        n = 0;
        while (!m_busy && n < 10) begin tick(); n++; end
        req_code = 5'b10000; req_hold = 16'd4;
        n = 0; lowcnt = 0;
        while (busy !== 1'b0 && n < 2000) begin tick(); n++; end
        while (busy !== 1'b1 && n < 2000) begin lowcnt++; tick(); n++; end
        req_valid = 1'b0;
        chk("b2b_busy_low_cycles", 32'(lowcnt), 32'd1);
        wait_idle();

        // Y index 5: error pulse, no contact, done after the gap
        keyX_in = 4'h0; keyY_in = 5'h00;
        e0 = err_cnt; d0 = done_cnt;
        send(5'b10100, 16'd7);
        chk("bad_code_err_pulse", 32'(code_err), 32'd1);
        anypd = |{keyX_pd, keyY_pd};
        n = 1;
        while (done !== 1'b1 && n < 1000) begin
            tick();
            n++;
            anypd = anypd | (|{keyX_pd, keyY_pd});
        end
        chk("bad_code_done_latency", 32'(n), 32'(G + 1));
        chk("bad_code_no_pd", 32'(anypd), 32'd0);
        chk("bad_code_err_count", 32'(err_cnt - e0), 32'd1);
        chk("bad_code_done_count", 32'(done_cnt - d0), 32'd1);
        tick();

        // Reset during HOLD
        send(5'b01101, 16'd300);
        repeat (B + 20) tick();
        tick();
        chk("hold_pd_before_reset", 32'(keyX_pd), 32'b0010);
        d0 = done_cnt;
        rst_n = 1'b0;
        tick();
        chk("pd_after_reset_edge", 32'({keyX_pd, keyY_pd}), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ready_after_midrun_reset", 32'(req_ready), 32'd1);
        chk("no_done_on_reset", 32'(done_cnt - d0), 32'd0);
        send(5'b01101, 16'd10);
        wait_idle();
        tick();
        chk("request_after_reset_done", 32'(done_cnt - d0), 32'd1);

        // Randomized traffic, line noise and occasional resets
        for (int c = 0; c < 6000; c++) begin
            keyX_in = 4'($urandom) | 4'($urandom) | 4'($urandom);
            keyY_in = 5'($urandom) | 5'($urandom) | 5'($urandom);
            req_valid = ($urandom % 4 == 0);
            req_code  = ($urandom % 8 == 0) ? {3'($urandom_range(5, 7)), 2'($urandom)}
                                            : {3'($urandom_range(0, 4)), 2'($urandom)};
            req_hold  = 16'($urandom_range(0, 20));
            rst_n     = ($urandom % 1500 != 0);
            tick();
        end
        rst_n = 1'b1;
        req_valid = 1'b0;
        tick();
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
